// File: rtl/float8_pkg.sv
// Shared types and field layout for the 8-bit float adder scheduler.
// Word layout: sign [7], exponent [6:3], fraction [2:0] with a hidden leading 1.
package float8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam int SIGN_BIT = 7;
    localparam int EXP_HI   = 6;
    localparam int EXP_LO   = 3;
    localparam int FRAC_HI  = 2;
    localparam int FRAC_LO  = 0;

    localparam logic [7:0] ZERO_WORD   = 8'h00;
    localparam logic [3:0] EXP_MAX     = 4'hF;
    localparam int         ALIGN_LIMIT = 4;

    // Working mantissa 8+frac; an exponent field of 0 encodes zero.
    function automatic logic [4:0] mantissa(input logic [7:0] w);
        if (w[EXP_HI:EXP_LO] == 4'd0) begin
            return 5'd0;
        end
        return {2'b01, w[FRAC_HI:FRAC_LO]};
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and moves to the other requester whenever a grant is taken.
module rr_arbiter_2 #(
    parameter bit FIRST_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt        = 2'b00;
            gnt[ptr_q] = 1'b1;
        end
        if (update && (req != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= FIRST_PRIORITY;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/float_add_scheduler.sv
// Arbitrates two requesters onto one multi-cycle 8-bit float adder and steps each
// addition through align, add and normalize, holding the result until acknowledged.
module float_add_scheduler
    import float8_pkg::*;
#(
    parameter bit FIRST_PRIORITY = 1'b0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       req_0,
    input  logic [7:0] a_0,
    input  logic [7:0] b_0,
    input  logic       req_1,
    input  logic [7:0] a_1,
    input  logic [7:0] b_1,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       result_valid,
    input  logic       result_ack,
    output logic [7:0] result,
    output logic       owner,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        sel_q, sel_d;
    logic [4:0]  mant_gt_q, mant_gt_d;
    logic [4:0]  mant_lt_q, mant_lt_d;
    logic [3:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [2:0]  d_q, d_d;
    logic [7:0]  result_q, result_d;
    logic        owner_q, owner_d;
    logic        valid_q, valid_d;

    logic [1:0]  arb_gnt;
    logic [7:0]  word_a, word_b, word_gt, word_lt;
    logic        a_is_gt;
    logic [3:0]  exp_diff;
    logic [4:0]  sum;
    logic [4:0]  exp_inc;
    logic        finish;

    rr_arbiter_2 #(.FIRST_PRIORITY(FIRST_PRIORITY)) u_arb (
        .clk    (clock),
        .srst   (clear),
        .req    ({req_1, req_0}),
        .update (state_q == ST_IDLE),
        .gnt    (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = 2'b00;
        sel_d     = sel_q;
        mant_gt_d = mant_gt_q;
        mant_lt_d = mant_lt_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        sub_d     = sub_q;
        d_d       = d_q;
        result_d  = result_q;
        owner_d   = owner_q;
        valid_d   = valid_q;
        finish    = 1'b0;

        word_a  = arb_gnt[1] ? a_1 : a_0;
        word_b  = arb_gnt[1] ? b_1 : b_0;
        // Magnitude order on raw fields; ties keep operand a as the larger.
        a_is_gt = (word_a[EXP_HI:EXP_LO] > word_b[EXP_HI:EXP_LO]) ||
                  ((word_a[EXP_HI:EXP_LO] == word_b[EXP_HI:EXP_LO]) &&
                   (word_a[FRAC_HI:FRAC_LO] >= word_b[FRAC_HI:FRAC_LO]));
        word_gt  = a_is_gt ? word_a : word_b;
        word_lt  = a_is_gt ? word_b : word_a;
        exp_diff = word_gt[EXP_HI:EXP_LO] - word_lt[EXP_HI:EXP_LO];
        sum      = sub_q ? (mant_gt_q - mant_lt_q) : (mant_gt_q + mant_lt_q);
        exp_inc  = {1'b0, exp_q} + 5'd1;

        case (state_q)
            ST_IDLE: begin
                if (req_0 || req_1) begin
                    gnt_d     = arb_gnt;
                    sel_d     = arb_gnt[1];
                    mant_gt_d = mantissa(word_gt);
                    mant_lt_d = mantissa(word_lt);
                    exp_d     = word_gt[EXP_HI:EXP_LO];
                    sign_d    = word_gt[SIGN_BIT];
                    sub_d     = word_gt[SIGN_BIT] ^ word_lt[SIGN_BIT];
                    d_d       = (exp_diff > 4'(ALIGN_LIMIT)) ? 3'(ALIGN_LIMIT) : exp_diff[2:0];
                    state_d   = (d_d != 3'd0) ? ST_ALIGN : ST_ADD;
                end
            end
            ST_ALIGN: begin
                mant_lt_d = mant_lt_q >> 1;
                d_d       = d_q - 3'd1;
                if (d_q == 3'd1) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                mant_gt_d = sum;
                if (sum == 5'd0) begin
                    result_d = ZERO_WORD;
                    finish   = 1'b1;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mant_gt_q[4]) begin
                    result_d = exp_inc[4] ? {sign_q, EXP_MAX, 3'h7}
                                          : {sign_q, exp_inc[3:0], mant_gt_q[3:1]};
                    finish   = 1'b1;
                end else if (mant_gt_q[3]) begin
                    result_d = {sign_q, exp_q, mant_gt_q[2:0]};
                    finish   = 1'b1;
                end else if (exp_q == 4'd1) begin
                    // Underflow: the next left shift would reach exponent 0.
                    result_d = ZERO_WORD;
                    finish   = 1'b1;
                end else begin
                    mant_gt_d = mant_gt_q << 1;
                    exp_d     = exp_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            owner_d = sel_q;
            valid_d = 1'b1;
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            sel_q     <= 1'b0;
            mant_gt_q <= 5'd0;
            mant_lt_q <= 5'd0;
            exp_q     <= 4'd0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            d_q       <= 3'd0;
            result_q  <= ZERO_WORD;
            owner_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            mant_gt_q <= mant_gt_d;
            mant_lt_q <= mant_lt_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            sub_q     <= sub_d;
            d_q       <= d_d;
            result_q  <= result_d;
            owner_q   <= owner_d;
            valid_q   <= valid_d;
        end
    end

    assign gnt_0        = gnt_q[0];
    assign gnt_1        = gnt_q[1];
    assign result       = result_q;
    assign owner        = owner_q;
    assign result_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_float_add_scheduler.sv
// Scoreboard bench for float_add_scheduler: expectations are queued at request time
// and popped when result_valid appears.
module tb_float_add_scheduler;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       req_0 = 1'b0;
    logic       req_1 = 1'b0;
    logic [7:0] a_0 = 8'h00, b_0 = 8'h00, a_1 = 8'h00, b_1 = 8'h00;
    logic       result_ack = 1'b0;
    logic       gnt_0, gnt_1, result_valid, owner, busy;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] res;
        logic       own;
        int         lat;
    } exp_t;

    exp_t sb[$];

    float_add_scheduler #(.FIRST_PRIORITY(1'b0)) dut (
        .clock        (clock),
        .clear        (clear),
        .req_0        (req_0),
        .a_0          (a_0),
        .b_0          (b_0),
        .req_1        (req_1),
        .a_1          (a_1),
        .b_1          (b_1),
        .gnt_0        (gnt_0),
        .gnt_1        (gnt_1),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .result       (result),
        .owner        (owner),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Stimulus table: requester, operands, expected sum, expected latency (-1 = not timed).
    logic       v_idx [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] v_a   [9] = '{8'h48, 8'h48, 8'h7F, 8'h48, 8'h78, 8'h00, 8'hC8, 8'h40, 8'h0F};
    logic [7:0] v_b   [9] = '{8'h48, 8'hC7, 8'h7F, 8'hC8, 8'h08, 8'h48, 8'h40, 8'h50, 8'h88};
    logic [7:0] v_res [9] = '{8'h50, 8'h30, 8'h7F, 8'h00, 8'h78, 8'h48, 8'hC0, 8'h52, 8'h00};
    int         v_lat [9] = '{2, 6, 2, 1, 6, 6, 4, 4, -1};

    task automatic wait_gnt(output logic [1:0] g);
        int n = 0;
        @(negedge clock);
        while ({gnt_1, gnt_0} == 2'b00 && n < 20) begin
            @(negedge clock);
            n++;
        end
        g = {gnt_1, gnt_0};
    endtask

    task automatic wait_valid(output int lat, output logic gnt_after);
        lat       = 0;
        gnt_after = 1'b0;
        while (result_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
            if (lat == 1) gnt_after = gnt_0 | gnt_1;
        end
    endtask

    task automatic pulse_ack(input logic drop_reqs);
        result_ack = 1'b1;
        if (drop_reqs) begin
            req_0 = 1'b0;
            req_1 = 1'b0;
        end
        @(negedge clock);
        result_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({gnt_1, gnt_0, result_valid, owner, busy, result} !== 13'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b valid=%b owner=%b busy=%b result=%h want all zero",
                     {gnt_1, gnt_0}, result_valid, owner, busy, result);
        end
        clear = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, result_valid);
        end
        $display("reset: busy=%b valid=%b result=%h", busy, result_valid, result);
    endtask

    task automatic test_single();
        for (int i = 0; i < 9; i++) begin
            exp_t       e;
            logic [1:0] g;
            logic [1:0] g_exp;
            int         lat;
            logic       ga;
            e.res = v_res[i];
            e.own = v_idx[i];
            e.lat = v_lat[i];
            sb.push_back(e);
            if (v_idx[i]) begin
                a_1 = v_a[i]; b_1 = v_b[i]; req_1 = 1'b1;
            end else begin
                a_0 = v_a[i]; b_0 = v_b[i]; req_0 = 1'b1;
            end
            g_exp = v_idx[i] ? 2'b10 : 2'b01;
            wait_gnt(g);
            checks++;
            if (g !== g_exp) begin
                errors++;
                $display("FAIL single%0d_gnt: got %b want %b", i, g, g_exp);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL single%0d_busy: got %b want 1", i, busy);
            end
            req_0 = 1'b0;
            req_1 = 1'b0;
            wait_valid(lat, ga);
            e = sb.pop_front();
            checks++;
            if (result !== e.res || owner !== e.own) begin
                errors++;
                $display("FAIL single%0d_result: got %h/%b want %h/%b", i, result, owner, e.res, e.own);
            end
            if (e.lat >= 0) begin
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("FAIL single%0d_latency: got %0d want %0d", i, lat, e.lat);
                end
            end
            checks++;
            if (ga !== 1'b0) begin
                errors++;
                $display("FAIL single%0d_gnt_pulse: gnt still high one cycle later, want low", i);
            end
            $display("op %0d: req%0d a=%h b=%h -> result=%h owner=%0d lat=%0d",
                     i, v_idx[i], v_a[i], v_b[i], result, owner, lat);
            pulse_ack(1'b0);
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL single%0d_ack: got valid=%b busy=%b want 0 0", i, result_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_0 = 8'h48; b_0 = 8'h48;
        a_1 = 8'h7F; b_1 = 8'h7F;
        req_0 = 1'b1;
        req_1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t       e;
            logic [1:0] g;
            logic [1:0] g_exp;
            int         lat;
            logic       ga;
            e.own = (k == 1);
            e.res = e.own ? 8'h7F : 8'h50;
            e.lat = 2;
            sb.push_back(e);
            g_exp = e.own ? 2'b10 : 2'b01;
            wait_gnt(g);
            checks++;
            if (g !== g_exp) begin
                errors++;
                $display("FAIL b2b%0d_gnt: got %b want %b", k, g, g_exp);
            end
            wait_valid(lat, ga);
            e = sb.pop_front();
            checks++;
            if (result !== e.res || owner !== e.own || lat !== e.lat) begin
                errors++;
                $display("FAIL b2b%0d_result: got %h/%b lat %0d want %h/%b lat %0d",
                         k, result, owner, lat, e.res, e.own, e.lat);
            end
            if (k == 0) begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clock);
                    checks++;
                    if (result !== e.res || owner !== e.own || result_valid !== 1'b1 ||
                        gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_hold%0d: got %h/%b valid=%b gnt=%b want %h/%b valid=1 gnt=00",
                                 j, result, owner, result_valid, {gnt_1, gnt_0}, e.res, e.own);
                    end
                end
            end
            $display("b2b %0d: grant=%b result=%h owner=%0d lat=%0d", k, g, result, owner, lat);
            pulse_ack(k == 2);
        end
    endtask

    task automatic test_clear();
        exp_t       e;
        logic [1:0] g;
        int         lat;
        logic       ga;
        logic       seen;

        // Complete one op on requester 1 so result/owner are non-zero before clearing.
        a_1 = 8'h7F; b_1 = 8'h7F; req_1 = 1'b1;
        wait_gnt(g);
        req_1 = 1'b0;
        wait_valid(lat, ga);
        checks++;
        if (result !== 8'h7F || owner !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre: got %h/%b want 7f/1", result, owner);
        end
        pulse_ack(1'b0);

        a_0 = 8'h48; b_0 = 8'hC7; req_0 = 1'b1;
        wait_gnt(g);
        req_0 = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_inflight: got busy=%b valid=%b want 1 0", busy, result_valid);
        end
        clear = 1'b1;
        @(negedge clock);
        checks++;
        if ({gnt_1, gnt_0, result_valid, owner, busy, result} !== 13'h0000) begin
            errors++;
            $display("FAIL clear_outputs: got gnt=%b valid=%b owner=%b busy=%b result=%h want all zero",
                     {gnt_1, gnt_0}, result_valid, owner, busy, result);
        end
        clear = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            seen = seen | result_valid | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL clear_discard: got activity after clear want none");
        end
        $display("clear: outputs reset, in-flight op discarded");

        // Last grant before clear went to 0; reset pointer must favour 0 again.
        a_0 = 8'h48; b_0 = 8'h48; a_1 = 8'h7F; b_1 = 8'h7F;
        req_0 = 1'b1; req_1 = 1'b1;
        e.res = 8'h50; e.own = 1'b0; e.lat = 2;
        sb.push_back(e);
        wait_gnt(g);
        checks++;
        if (g !== 2'b01) begin
            errors++;
            $display("FAIL clear_priority: got %b want 01", g);
        end
        req_0 = 1'b0; req_1 = 1'b0;
        wait_valid(lat, ga);
        e = sb.pop_front();
        checks++;
        if (result !== e.res || owner !== e.own || lat !== e.lat) begin
            errors++;
            $display("FAIL clear_prio_result: got %h/%b lat %0d want %h/%b lat %0d",
                     result, owner, lat, e.res, e.own, e.lat);
        end
        $display("post-clear both: grant=%b result=%h owner=%0d", g, result, owner);
        pulse_ack(1'b0);

        a_1 = 8'h48; b_1 = 8'hC8; req_1 = 1'b1;
        e.res = 8'h00; e.own = 1'b1; e.lat = 1;
        sb.push_back(e);
        wait_gnt(g);
        checks++;
        if (g !== 2'b10) begin
            errors++;
            $display("FAIL clear_single1: got %b want 10", g);
        end
        req_1 = 1'b0;
        wait_valid(lat, ga);
        e = sb.pop_front();
        checks++;
        if (result !== e.res || owner !== e.own || lat !== e.lat) begin
            errors++;
            $display("FAIL clear_single1_result: got %h/%b lat %0d want %h/%b lat %0d",
                     result, owner, lat, e.res, e.own, e.lat);
        end
        $display("post-clear req1: grant=%b result=%h owner=%0d lat=%0d", g, result, owner, lat);
        pulse_ack(1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
